// File: rtl/rr_sel4_pkg.sv
// rr_sel4_pkg
// Shared constants and types for the four-lane round-robin selector.
//   NUM_LANES  : number of requesting lanes
//   SEL_W      : width of the lane select driven to the output mux
//   CNT_W      : width of the idle-timeout counter
//   rr_state_t : arbitration FSM state (IDLE / LOCKED)
package rr_sel4_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W     = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rr_state_t;

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Purely combinational round-robin picker. Scans lanes starting just after
// the last served lane (ptr+1, ptr+2, ptr+3, ptr, all mod 4) and reports the
// first requesting one.
// Ports:
//   req [3:0] in  : per-lane request
//   ptr [1:0] in  : last served lane
//   idx [1:0] out : chosen lane (only meaningful when any = 1)
//   any       out : at least one lane is requesting
module rr_pick4
  import rr_sel4_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  logic [SEL_W-1:0]     ptr,
  output logic [SEL_W-1:0]     idx,
  output logic                 any
);

  logic [SEL_W-1:0] cand;
  logic             found;

  // The candidate index wraps naturally in SEL_W bits, so ptr+4 lands back
  // on ptr itself, which gives the last-served lane the lowest priority.
  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_sel4.sv
// rr_sel4
// Four-lane round-robin selector driving the select of a registered 4:1
// output mux. A lane wins arbitration, then owns the mux until it sends a
// beat marked last, or until it stays silent for IDLE_TIMEOUT cycles.
// Lane data never passes through here; only control.
// Parameters:
//   IDLE_TIMEOUT    : silent cycles tolerated from a locked lane (1..255)
// Ports:
//   clk             : rising-edge clock shared with the mux
//   reset           : asynchronous, active-low reset
//   req [3:0]  in   : per-lane beat valid
//   last [3:0] in   : per-lane end-of-burst, qualified by req
//   gnt [3:0]  out  : one-hot transfer strobe for the accepted beat
//   sel [1:0]  out  : registered mux select
//   out_ready  in   : downstream can take a beat this cycle
//   out_valid  out  : selected lane is presenting a beat
//   dat_valid  out  : registered, marks the mux output cycle of a transfer
module rr_sel4
  import rr_sel4_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LANES-1:0] req,
  input  logic [NUM_LANES-1:0] last,
  output logic [NUM_LANES-1:0] gnt,
  output logic [SEL_W-1:0]     sel,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic                 dat_valid
);

  // The counter value seen on the final silent cycle before release.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  rr_state_t        state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // State register. ptr resets to 3 so lane 0 is first in line after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sel      <= '0;
      ptr      <= SEL_W'(NUM_LANES - 1);
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Next-state logic. sel is only ever loaded on IDLE->LOCKED, so a locked
  // burst is immune to whatever the other lanes are doing. A stalled beat
  // (req high, out_ready low) leaves every register untouched.
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    ptr_nxt      = ptr;
    idle_cnt_nxt = idle_cnt;
    case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (pick_any) begin
          sel_nxt   = pick_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (req[sel]) begin
          if (out_ready) begin
            idle_cnt_nxt = '0;
            if (last[sel]) begin
              ptr_nxt   = sel;
              state_nxt = IDLE;
            end
          end
        end else if (idle_cnt == TIMEOUT_LAST) begin
          ptr_nxt      = sel;
          idle_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic. gnt and out_valid depend only on registered state and the
  // live req/out_ready, never on the picker, so there is no path into sel.
  always_comb begin
    gnt       = '0;
    out_valid = 1'b0;
    if (state == LOCKED) begin
      out_valid = req[sel];
      gnt[sel]  = req[sel] & out_ready;
    end
  end

  // dat_valid trails a transfer by one cycle to line up with the mux's
  // registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dat_valid <= 1'b0;
    end else begin
      dat_valid <= |gnt;
    end
  end

  gnt_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(gnt));

  sel_locked_stable: assert property (@(posedge clk) disable iff (!reset)
    (state == LOCKED && state_nxt == LOCKED) |=> $stable(sel));

endmodule

// File: tb/tb_rr_sel4.sv
// tb_rr_sel4
// Self-checking bench for rr_sel4 and its rr_pick4 picker. Expected grant
// vectors are queued as each scenario is driven and popped by a monitor
// whenever the selector grants; per-cycle sel/gnt/out_valid/dat_valid
// values are also checked against hand-derived constants.
module tb_rr_sel4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] last;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       dat_valid;

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic [1:0] pk_idx;
  logic       pk_any;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] exp_q[$];

  rr_sel4 #(.IDLE_TIMEOUT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .last      (last),
    .gnt       (gnt),
    .sel       (sel),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dat_valid (dat_valid)
  );

  rr_pick4 u_pick_tb (
    .req (pk_req),
    .ptr (pk_ptr),
    .idx (pk_idx),
    .any (pk_any)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [1:0] exp_sel, input logic [3:0] exp_gnt,
                            input logic exp_ov, input logic exp_dv);
    checkOutput({tag, "_sel"}, {6'd0, sel}, {6'd0, exp_sel});
    checkOutput({tag, "_gnt"}, {4'd0, gnt}, {4'd0, exp_gnt});
    checkOutput({tag, "_ov"},  {7'd0, out_valid}, {7'd0, exp_ov});
    checkOutput({tag, "_dv"},  {7'd0, dat_valid}, {7'd0, exp_dv});
  endtask

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy);
    @(posedge clk);
    #1;
    req       = r;
    last      = l;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req       = 4'b0000;
    last      = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);
    checkCycle("rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard: every grant the selector issues must match the next queued one.
  always @(negedge clk) begin
    if (gnt !== 4'b0000) begin
      if (exp_q.size() == 0)
        checkOutput("gnt_unexpected", {4'd0, gnt}, 8'h00);
      else
        checkOutput("gnt_order", {4'd0, gnt}, {4'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int lanes[5] = '{0, 1, 2, 3, 0};
    logic [1:0] prev_sel;
    logic [7:0] dbl;
    logic [3:0] rot;
    int         low;

    reset     = 1'b0;
    req       = 4'b0000;
    last      = 4'b0000;
    out_ready = 1'b0;
    pk_req    = 4'b0000;
    pk_ptr    = 2'd0;

    doReset();

    // Single-beat burst on lane 0.
    exp_q.push_back(4'b0001);
    applyStimulus(4'b0001, 4'b0001, 1'b1); checkCycle("t1_arb",  2'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b1); checkCycle("t1_beat", 2'd0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1); checkCycle("t1_dv",   2'd0, 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b1); checkCycle("t1_idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // All lanes requesting, two-beat bursts, rotation 0,1,2,3,0.
    doReset();
    foreach (lanes[b]) begin
      exp_q.push_back(4'b0001 << lanes[b]);
      exp_q.push_back(4'b0001 << lanes[b]);
    end
    prev_sel = 2'd0;
    foreach (lanes[b]) begin
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkCycle("t2_gap", prev_sel, 4'b0000, 1'b0, (b == 0) ? 1'b0 : 1'b1);
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkCycle("t2_beat1", 2'(lanes[b]), 4'b0001 << lanes[b], 1'b1, 1'b0);
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkCycle("t2_beat2", 2'(lanes[b]), 4'b0001 << lanes[b], 1'b1, 1'b1);
      prev_sel = 2'(lanes[b]);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b1); checkCycle("t2_end", 2'd0, 4'b0000, 1'b0, 1'b1);

    // Lane 2 stalled by downstream for three cycles.
    doReset();
    exp_q.push_back(4'b0100);
    applyStimulus(4'b0100, 4'b0000, 1'b0); checkCycle("t3_arb", 2'd0, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0100, 4'b0100, 1'b0); checkCycle("t3_stall", 2'd2, 4'b0000, 1'b1, 1'b0);
    end
    applyStimulus(4'b0100, 4'b0100, 1'b1); checkCycle("t3_xfer", 2'd2, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1); checkCycle("t3_dv",   2'd2, 4'b0000, 1'b0, 1'b1);

    // Lane 1 goes silent for IDLE_TIMEOUT cycles while others request.
    doReset();
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    applyStimulus(4'b0010, 4'b0000, 1'b1); checkCycle("t4_arb",  2'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b1); checkCycle("t4_beat", 2'd1, 4'b0010, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(4'b1101, 4'b1101, 1'b1);
      checkCycle("t4_wait", 2'd1, 4'b0000, 1'b0, (k == 1) ? 1'b1 : 1'b0);
    end
    applyStimulus(4'b1101, 4'b1101, 1'b1); checkCycle("t4_rearb", 2'd1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1101, 4'b0100, 1'b1); checkCycle("t4_next",  2'd2, 4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1); checkCycle("t4_dv",    2'd2, 4'b0000, 1'b0, 1'b1);

    // Reset pulsed in the middle of a lane 3 burst.
    doReset();
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b1000);
    applyStimulus(4'b1000, 4'b0000, 1'b1); checkCycle("t5_arb",  2'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b1); checkCycle("t5_beat", 2'd3, 4'b1000, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkCycle("t5_async", 2'd0, 4'b0000, 1'b0, 1'b0);
    doReset();
    applyStimulus(4'b1000, 4'b1000, 1'b1); checkCycle("t5_arb2",    2'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b1000, 1'b1); checkCycle("t5_regrant", 2'd3, 4'b1000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1); checkCycle("t5_dv",      2'd3, 4'b0000, 1'b0, 1'b1);

    // Exhaustive picker check: rotate req so lane ptr+1 sits at bit 0,
    // take the lowest set bit, then rotate the index back.
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 4; p++) begin
        pk_req = 4'(r);
        pk_ptr = 2'(p);
        #1;
        dbl = {4'(r), 4'(r)};
        rot = 4'(dbl >> ((p + 1) % 4));
        low = -1;
        for (int j = 3; j >= 0; j--) if (rot[j]) low = j;
        checkOutput("pick_any", {7'd0, pk_any}, {7'd0, (r != 0)});
        if (low >= 0)
          checkOutput("pick_idx", {6'd0, pk_idx}, {6'd0, 2'((p + 1 + low) % 4)});
      end
    end

    checkOutput("sb_drain", 8'(exp_q.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
